instr_fetch: RTL and testbench

- Instruction fetch sequencer that produces the 32-bit instruction word consumed by the SISC datapath top as `ir`.
- Owns the program counter and reads instruction memory through a req/ack handshake.
- Holds the word stable while the control unit executes it, then fetches the next word.
- Applies branch redirects from the control unit, stops on HALT, and flags memory-ack timeouts.

---
 rtl/sisc_pkg.sv | 30 +++
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: fetch sequencer states, opcode map and fetch defaults.
// Imported by the fetch sequencer, its memory interface and the control unit.
package sisc_pkg;

  localparam int          DEF_AW       = 16;
  localparam logic [15:0] DEF_RST_PC   = 16'h0000;
  localparam int          DEF_MAX_WAIT = 15;

  // Opcode lives in ir[31:28]; OP_HALT is the only one fetch itself decodes.
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_BR   = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [31:0] word);
    return word[31:28];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port between the fetch sequencer (master) and memory (slave).
// Handshake: im_req stays high with im_addr stable until a cycle where im_ack=1;
// im_rdata is valid in that same cycle and the transfer completes on that clock edge.
interface instr_fetch_if #(
  parameter int AW = 16
) ();

  logic          im_req;
  logic [AW-1:0] im_addr;
  logic          im_ack;
  logic [31:0]   im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_ack,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_ack,
    output im_rdata
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: owns the PC, fetches one word at a time into ir,
// holds it while the control unit executes, applies branches, stops on HALT or ack timeout.
module instr_fetch
  import sisc_pkg::*;
#(
  parameter int            AW       = DEF_AW,
  parameter logic [AW-1:0] RST_PC   = AW'(DEF_RST_PC),
  parameter logic [3:0]    HALT_OP  = OP_HALT,
  parameter int            MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic          clk,
  input  logic          rst_f,
  instr_fetch_if.master im,
  output logic [31:0]   ir,
  output logic          ir_valid,
  input  logic          next_instr,
  input  logic          br_taken,
  input  logic [AW-1:0] br_addr,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          fetch_err,
  output fetch_state_e  dbg_state
);

  fetch_state_e  r_state;
  logic [AW-1:0] r_pc;
  logic [31:0]   r_ir;
  logic          r_ir_valid;
  logic          r_im_req;
  logic          r_halted;
  logic          r_fetch_err;
  logic [7:0]    r_wait_cnt;

  logic [AW-1:0] w_pc_inc;
  logic [7:0]    w_wait_next;
  logic          w_ack;
  logic          w_is_halt;
  logic          w_timeout;

  assign w_pc_inc    = r_pc + AW'(1);
  assign w_wait_next = r_wait_cnt + 8'd1;
  // An ack only counts while a request is actually outstanding.
  assign w_ack       = r_im_req && im.im_ack;
  assign w_is_halt   = (opcode_of(im.im_rdata) == HALT_OP);
  assign w_timeout   = (w_wait_next == 8'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state     <= ST_BOOT;
      r_pc        <= RST_PC;
      r_ir        <= '0;
      r_ir_valid  <= 1'b0;
      r_im_req    <= 1'b0;
      r_halted    <= 1'b0;
      r_fetch_err <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state    <= ST_FETCH;
          r_im_req   <= 1'b1;
          r_wait_cnt <= '0;
        end

        ST_FETCH: begin
          if (w_ack) begin
            r_ir       <= im.im_rdata;
            r_ir_valid <= 1'b1;
            r_pc       <= w_pc_inc;
            r_im_req   <= 1'b0;
            r_wait_cnt <= '0;
            if (w_is_halt) begin
              r_state  <= ST_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_state  <= ST_EXEC;
            end
          end else if (w_timeout) begin
            r_fetch_err <= 1'b1;
            r_halted    <= 1'b1;
            r_im_req    <= 1'b0;
            r_wait_cnt  <= w_wait_next;
            r_state     <= ST_HALTED;
          end else begin
            r_wait_cnt  <= w_wait_next;
          end
        end

        ST_EXEC: begin
          // pc already points past ir; a taken branch overrides that increment.
          if (next_instr) begin
            r_ir_valid <= 1'b0;
            r_im_req   <= 1'b1;
            r_wait_cnt <= '0;
            r_state    <= ST_FETCH;
            if (br_taken) begin
              r_pc <= br_addr;
            end
          end
        end

        ST_HALTED: begin
          r_state <= ST_HALTED;
        end

        default: begin
          r_state  <= ST_HALTED;
          r_im_req <= 1'b0;
        end
      endcase
    end
  end

  assign im.im_req  = r_im_req;
  assign im.im_addr = r_pc;
  assign ir         = r_ir;
  assign ir_valid   = r_ir_valid;
  assign pc         = r_pc;
  assign halted     = r_halted;
  assign fetch_err  = r_fetch_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, wait states, branch, HALT,
// ack timeout, async reset, plus a second instance reset to 16'hFFFF for PC wrap.
module tb_instr_fetch;
  import sisc_pkg::*;

  localparam int AW = 16;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_f = 1'b1;
  always #5 clk = ~clk;

  logic          next_instr = 1'b0;
  logic          br_taken   = 1'b0;
  logic [AW-1:0] br_addr    = '0;

  instr_fetch_if #(.AW(AW)) im   ();
  instr_fetch_if #(.AW(AW)) im_w ();

  logic [31:0]   ir, ir_w;
  logic          ir_valid, ir_valid_w;
  logic [AW-1:0] pc, pc_w;
  logic          halted, halted_w;
  logic          fetch_err, fetch_err_w;
  fetch_state_e  dbg_state, dbg_state_w;

  instr_fetch #(.AW(AW)) u_dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .im         (im),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .next_instr (next_instr),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .pc         (pc),
    .halted     (halted),
    .fetch_err  (fetch_err),
    .dbg_state  (dbg_state)
  );

  instr_fetch #(.AW(AW), .RST_PC(16'hFFFF)) u_dut_wrap (
    .clk        (clk),
    .rst_f      (rst_f),
    .im         (im_w),
    .ir         (ir_w),
    .ir_valid   (ir_valid_w),
    .next_instr (next_instr),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .pc         (pc_w),
    .halted     (halted_w),
    .fetch_err  (fetch_err_w),
    .dbg_state  (dbg_state_w)
  );

  // memory model for the main instance: ack after ack_delay request cycles
  logic [31:0] mem [256];
  int          ack_delay = 0;
  logic        ack_en    = 1'b1;
  int          req_cycles;

  always @(posedge clk or negedge rst_f) begin
    if (!rst_f) req_cycles <= 0;
    else if (im.im_req && !im.im_ack) req_cycles <= req_cycles + 1;
    else req_cycles <= 0;
  end

  assign im.im_ack   = ack_en && im.im_req && (req_cycles >= ack_delay);
  assign im.im_rdata = mem[im.im_addr[7:0]];

  // wrap instance: zero-wait memory returning a non-HALT word tagged with the address
  assign im_w.im_ack   = im_w.im_req;
  assign im_w.im_rdata = {16'h1000, im_w.im_addr};

  // scoreboard counters and checker
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_next();
    next_instr = 1'b1;
    tick();
    next_instr = 1'b0;
    tick();
  endtask

  int n_req;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {16'hA5A5, 16'(i)};
    mem[0]     = 32'h88120001;
    mem[1]     = 32'h88230002;
    mem[8'h41] = 32'hF0000000;

    // reset values, before any clock edge
    #1 rst_f = 1'b0;
    #2;
    check("rst_state",    64'(dbg_state), 64'(ST_BOOT));
    check("rst_pc",       64'(pc), 64'h0);
    check("rst_ir",       64'(ir), 64'h0);
    check("rst_ir_valid", 64'(ir_valid), 64'h0);
    check("rst_im_req",   64'(im.im_req), 64'h0);
    check("rst_halted",   64'(halted), 64'h0);
    check("rst_fetch_err",64'(fetch_err), 64'h0);
    check("rst_pc_wrap",  64'(pc_w), 64'hFFFF);

    // sequential fetch, zero-wait
    @(negedge clk) rst_f = 1'b1;
    tick();
    check("seq0_state",   64'(dbg_state), 64'(ST_FETCH));
    check("seq0_req",     64'(im.im_req), 64'h1);
    check("seq0_addr",    64'(im.im_addr), 64'h0);
    check("wrap_addr0",   64'(im_w.im_addr), 64'hFFFF);
    tick();
    check("seq0_ir",      64'(ir), 64'h88120001);
    check("seq0_valid",   64'(ir_valid), 64'h1);
    check("seq0_pc",      64'(pc), 64'h1);
    check("seq0_req_lo",  64'(im.im_req), 64'h0);
    check("seq0_state_x", 64'(dbg_state), 64'(ST_EXEC));
    check("wrap_pc",      64'(pc_w), 64'h0000);
    check("wrap_ir",      64'(ir_w), 64'h1000FFFF);
    next_instr = 1'b1;
    tick();
    next_instr = 1'b0;
    check("seq1_addr",    64'(im.im_addr), 64'h1);
    check("seq1_valid",   64'(ir_valid), 64'h0);
    check("wrap_req1",    64'(im_w.im_req), 64'h1);
    check("wrap_addr1",   64'(im_w.im_addr), 64'h0000);
    tick();
    check("seq1_ir",      64'(ir), 64'h88230002);
    check("seq1_pc",      64'(pc), 64'h2);

    // wait states: ack after 3 extra request cycles
    ack_delay = 3;
    next_instr = 1'b1;
    tick();
    next_instr = 1'b0;
    n_req = 0;
    for (int i = 0; i < 10; i++) begin
      if (!im.im_req) break;
      n_req++;
      check("ws_addr", 64'(im.im_addr), 64'h2);
      check("ws_ir",   64'(ir), 64'h88230002);
      tick();
    end
    check("ws_req_cycles", 64'(n_req), 64'd4);
    check("ws_ir_new",     64'(ir), 64'hA5A50002);
    check("ws_pc",         64'(pc), 64'h3);
    check("ws_fetch_err",  64'(fetch_err), 64'h0);

    // branch redirect from pc=5
    ack_delay = 0;
    fetch_next();
    fetch_next();
    check("br_pre_pc", 64'(pc), 64'h5);
    br_taken = 1'b1;
    br_addr  = 16'h0040;
    tick();
    tick();
    check("br_only_state", 64'(dbg_state), 64'(ST_EXEC));
    check("br_only_pc",    64'(pc), 64'h5);
    check("br_only_req",   64'(im.im_req), 64'h0);
    next_instr = 1'b1;
    tick();
    next_instr = 1'b0;
    br_taken   = 1'b0;
    check("br_req",  64'(im.im_req), 64'h1);
    check("br_addr", 64'(im.im_addr), 64'h0040);
    tick();
    check("br_pc",   64'(pc), 64'h0041);
    check("br_ir",   64'(ir), 64'hA5A50040);

    // HALT word at 0x41
    fetch_next();
    check("halt_halted", 64'(halted), 64'h1);
    check("halt_valid",  64'(ir_valid), 64'h1);
    check("halt_ir",     64'(ir), 64'hF0000000);
    check("halt_state",  64'(dbg_state), 64'(ST_HALTED));
    check("halt_pc",     64'(pc), 64'h0042);
    n_req = 0;
    for (int i = 0; i < 4; i++) begin
      next_instr = 1'b1;
      tick();
      next_instr = 1'b0;
      if (im.im_req) n_req++;
    end
    check("halt_no_req", 64'(n_req), 64'd0);
    check("halt_sticky", 64'(halted), 64'h1);

    // async reset from HALTED clears outputs without a clock
    #3 rst_f = 1'b0;
    #1;
    check("arst_halted", 64'(halted), 64'h0);
    check("arst_valid",  64'(ir_valid), 64'h0);
    check("arst_ir",     64'(ir), 64'h0);
    check("arst_pc",     64'(pc), 64'h0);

    // async reset while a fetch is outstanding
    ack_en = 1'b0;
    @(negedge clk) rst_f = 1'b1;
    tick();
    tick();
    check("mid_req_pre", 64'(im.im_req), 64'h1);
    #3 rst_f = 1'b0;
    #1;
    check("mid_req",   64'(im.im_req), 64'h0);
    check("mid_state", 64'(dbg_state), 64'(ST_BOOT));
    ack_en = 1'b1;
    tick();
    check("mid_hold_req", 64'(im.im_req), 64'h0);
    @(negedge clk) rst_f = 1'b1;
    tick();
    check("mid_restart_req",  64'(im.im_req), 64'h1);
    check("mid_restart_addr", 64'(im.im_addr), 64'h0);
    tick();
    check("mid_restart_ir",   64'(ir), 64'h88120001);
    check("mid_restart_pc",   64'(pc), 64'h1);

    // ack timeout: memory never answers
    #3 rst_f = 1'b0;
    ack_en = 1'b0;
    @(negedge clk) rst_f = 1'b1;
    tick();
    n_req = 0;
    for (int i = 0; i < 40; i++) begin
      if (!im.im_req) break;
      n_req++;
      check("to_no_err", 64'(fetch_err), 64'h0);
      tick();
    end
    check("to_req_cycles", 64'(n_req), 64'd15);
    check("to_fetch_err",  64'(fetch_err), 64'h1);
    check("to_halted",     64'(halted), 64'h1);
    check("to_req",        64'(im.im_req), 64'h0);
    check("to_valid",      64'(ir_valid), 64'h0);
    check("to_ir",         64'(ir), 64'h0);
    check("to_state",      64'(dbg_state), 64'(ST_HALTED));
    ack_en = 1'b1;
    next_instr = 1'b1;
    tick();
    tick();
    next_instr = 1'b0;
    check("to_absorb_req", 64'(im.im_req), 64'h0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
